// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS memory-port arbiter.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    // Lane 0 sits in bits 31:24, so byte lanes are declared [0:LANE_MSB].
    localparam int LANE_MSB = 3;

endpackage

// File: rtl/mips_arb_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module mips_arb_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises fetch and load/store traffic onto one word-wide memory port.
// Define MIPS_ARB_STATS_EN to add saturating grant/stall statistics outputs.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int MEM_LAT      = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     halted,
    input  logic                     if_req,
    input  logic [31:0]              if_addr,
    output logic [31:0]              if_rdata,
    output logic                     if_valid,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic [31:0]              d_rdata,
    output logic                     d_valid,
    output logic                     d_err,
    output logic [31:0]              mem_addr,
    output logic [0:LANE_MSB][7:0]   mem_data_in,
    input  logic [0:LANE_MSB][7:0]   mem_data_out,
    output logic                     mem_write_en,
    output logic                     arb_idle
`ifdef MIPS_ARB_STATS_EN
    ,
    output logic [31:0]              stat_if_grants,
    output logic [31:0]              stat_d_grants,
    output logic [31:0]              stat_stall
`endif
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic             grant_if, grant_d;
    logic             d_misaligned;
    logic [31:0]      rd_word;
    logic             unused_if_lsb;

    assign rd_word       = mem_data_out;
    assign d_misaligned  = (d_addr[1:0] != 2'b00);
    // Fetch addresses are word-forced, so the low bits never matter.
    assign unused_if_lsb = ^if_addr[1:0];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        we_d       = we_q;
        err_d      = err_q;
        grant_if   = 1'b0;
        grant_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    run_d = '0;
                end
                if (!halted) begin
                    if (d_req && !(if_req && (run_q == RUN_MAX))) begin
                        grant_d = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_d) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    err_d   = d_misaligned;
                    cnt_d   = CNT_INIT;
                    if (if_req) begin
                        run_d = run_q + RUN_W'(1);
                    end
                    // Misaligned accesses never touch the port, so its outputs keep their values.
                    if (d_misaligned) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_INIT;
                    run_d   = '0;
                    addr_d  = {if_addr[31:2], 2'b00};
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = rd_word;
                    end else if (!we_q) begin
                        d_rdata_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            run_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    // The counter still holds its load value only in the first BUSY cycle.
    assign mem_write_en = (state_q == BUSY) && (owner_q == OWN_D) && we_q && (cnt_q == CNT_INIT);
    assign if_valid     = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_valid      = (state_q == RESP) && (owner_q == OWN_D);
    assign d_err        = d_valid && err_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign arb_idle     = (state_q == IDLE);

`ifdef MIPS_ARB_STATS_EN
    logic stall;
    assign stall = (if_req || d_req) && !(grant_if || grant_d);

    mips_arb_sat_counter #(.W(32)) u_stat_if (
        .clk   (clk),
        .rst   (rst_b),
        .inc   (grant_if),
        .count (stat_if_grants)
    );

    mips_arb_sat_counter #(.W(32)) u_stat_d (
        .clk   (clk),
        .rst   (rst_b),
        .inc   (grant_d),
        .count (stat_d_grants)
    );

    mips_arb_sat_counter #(.W(32)) u_stat_stall (
        .clk   (clk),
        .rst   (rst_b),
        .inc   (stall),
        .count (stat_stall)
    );
`endif

endmodule
